// File: rtl/multdiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_ctrl_pkg
// Description : Shared definitions for the EX-stage multiply/divide
//               controller: function codes, FSM state encodings, default
//               unit latencies and small decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_ctrl_pkg;

    // Width of the function-code bus.
    localparam int FUNCT_BUS = 6;

    // Function codes of the instructions handled here.
    localparam logic [FUNCT_BUS-1:0] FUNCT_NOP   = 6'h00;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'h1B;

    // Default unit latencies (cycles of stable operands before result valid).
    localparam int MD_MULT_LAT = 1;
    localparam int MD_DIV_LAT  = 40;

    // Controller state encodings.
    localparam int          ST_W    = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    function automatic logic is_mult(input logic [FUNCT_BUS-1:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

    function automatic logic is_div(input logic [FUNCT_BUS-1:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

endpackage : multdiv_ctrl_pkg
`default_nettype wire

// File: rtl/multdiv_ctrl_hilo_reg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_reg
// Description : Architectural HI/LO storage with two write ports.
//               Capture port writes both halves from the unit result;
//               MTHI/MTLO port writes one half from a 32-bit source.
// Ports       : clk, rst (async active-low)
//               cap_we, cap_data[63:0] - {hi, lo} capture
//               mt_hi_we, mt_lo_we, mt_data[31:0] - single-half write
//               hi, lo - register contents
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_we,
    input  logic [63:0] cap_data,
    input  logic        mt_hi_we,
    input  logic        mt_lo_we,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // Capture and MTHI/MTLO are mutually exclusive by construction in the
    // controller (capture only in WAIT, moves only in IDLE); capture wins
    // regardless so the priority is well defined.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (cap_we) begin
            r_hi <= cap_data[63:32];
            r_lo <= cap_data[31:0];
        end else begin
            if (mt_hi_we) r_hi <= mt_data;
            if (mt_lo_we) r_lo <= mt_data;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule : hilo_reg
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_ctrl
// Description : Sequencing controller for the EX-stage multiply/divide unit.
//               Latches operands on accept, holds them stable for the unit
//               latency while stalling the pipeline, commits the 64-bit
//               result to HI/LO and aborts cleanly on flush.
// Ports       : clk, rst (async active-low)
//               req_valid/req_funct/req_op1/req_op2 - EX instruction
//               flush, stall_all                    - pipeline control in
//               stall_req                           - stall request out
//               md_funct/md_op1/md_op2              - unit inputs
//               md_result[63:0]                     - unit result {hi, lo}
//               hi, lo                              - architectural HI/LO
//               busy                                - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT,
    parameter int CNT_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic [FUNCT_BUS-1:0] req_funct,
    input  logic [31:0]          req_op1,
    input  logic [31:0]          req_op2,
    input  logic                 flush,
    input  logic                 stall_all,
    output logic                 stall_req,
    output logic [FUNCT_BUS-1:0] md_funct,
    output logic [31:0]          md_op1,
    output logic [31:0]          md_op2,
    input  logic [63:0]          md_result,
    output logic [31:0]          hi,
    output logic [31:0]          lo,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    logic [ST_W-1:0]      r_state;
    logic [ST_W-1:0]      w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [FUNCT_BUS-1:0] r_funct;
    logic [31:0]          r_op1;
    logic [31:0]          r_op2;

    logic w_idle;
    logic w_req_ok;
    logic w_is_mult;
    logic w_is_div;
    logic w_accept;
    logic w_last;
    logic w_capture;
    logic w_mt_hi;
    logic w_mt_lo;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_idle    = (r_state == ST_IDLE);
    assign w_req_ok  = w_idle && req_valid && !flush;
    assign w_is_mult = is_mult(req_funct);
    assign w_is_div  = is_div(req_funct);

    // Divide by zero is not launched at all. The rst term keeps the
    // combinational stall request quiet while reset is held.
    assign w_accept  = rst && w_req_ok &&
                       (w_is_mult || (w_is_div && (req_op2 != 32'd0)));

    // Moves to HI/LO only take effect when the instruction actually
    // advances, hence the stall_all qualifier.
    assign w_mt_hi   = w_req_ok && !stall_all && (req_funct == FUNCT_MTHI);
    assign w_mt_lo   = w_req_ok && !stall_all && (req_funct == FUNCT_MTLO);

    // Last WAIT cycle: the unit has seen stable operands for LAT cycles.
    assign w_last    = (r_state == ST_WAIT) && (r_cnt == c_cnt_one);
    assign w_capture = w_last && !flush;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush)       w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                // Holding here while stalled stops the still-resident
                // instruction from being accepted a second time.
                if (flush || !stall_all) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall_req = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: stall_req = w_accept;
            ST_WAIT: begin
                stall_req = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: busy = 1'b1;
            default: begin
                stall_req = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter and operand latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= c_cnt_zero;
            r_funct <= FUNCT_NOP;
            r_op1   <= 32'd0;
            r_op2   <= 32'd0;
        end else if (w_accept) begin
            r_cnt   <= w_is_mult ? c_mult_load : c_div_load;
            r_funct <= req_funct;
            r_op1   <= req_op1;
            r_op2   <= req_op2;
        end else if (r_state == ST_WAIT) begin
            if (flush) begin
                r_cnt   <= c_cnt_zero;
                r_funct <= FUNCT_NOP;
            end else begin
                // Counts regardless of stall_all; the unit runs on.
                r_cnt <= r_cnt - c_cnt_one;
                if (w_last) r_funct <= FUNCT_NOP;
            end
        end
    end

    // Operands are forwarded raw; signedness is the unit's business.
    assign md_funct = r_funct;
    assign md_op1   = r_op1;
    assign md_op2   = r_op2;

    // ------------------------------------------------------------------
    // HI/LO storage
    // ------------------------------------------------------------------
    hilo_reg u_hilo (
        .clk      (clk),
        .rst      (rst),
        .cap_we   (w_capture),
        .cap_data (md_result),
        .mt_hi_we (w_mt_hi),
        .mt_lo_we (w_mt_lo),
        .mt_data  (req_op1),
        .hi       (hi),
        .lo       (lo)
    );

endmodule : multdiv_ctrl
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_ctrl
// Description : Self-checking bench for multdiv_ctrl. A behavioural unit
//               model only produces a correct result once it has seen the
//               same operands for its full latency; otherwise it returns a
//               poison pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;
    import multdiv_ctrl_pkg::*;

    localparam int c_mult_lat = 1;
    localparam int c_div_lat  = 40;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic [FUNCT_BUS-1:0] req_funct;
    logic [31:0]          req_op1;
    logic [31:0]          req_op2;
    logic                 flush;
    logic                 stall_all;
    logic                 stall_req;
    logic [FUNCT_BUS-1:0] md_funct;
    logic [31:0]          md_op1;
    logic [31:0]          md_op2;
    logic [63:0]          md_result;
    logic [31:0]          hi;
    logic [31:0]          lo;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;

    multdiv_ctrl #(
        .MULT_LAT (c_mult_lat),
        .DIV_LAT  (c_div_lat),
        .CNT_W    (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_funct (req_funct),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .flush     (flush),
        .stall_all (stall_all),
        .stall_req (stall_req),
        .md_funct  (md_funct),
        .md_op1    (md_op1),
        .md_op2    (md_op2),
        .md_result (md_result),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Unit model
    // ------------------------------------------------------------------
    function automatic logic [63:0] unit_calc(input logic [5:0] f,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        unit_calc = 64'hDEAD_BEEF_DEAD_BEEF;
        case (f)
            FUNCT_MULT: begin
                sp = 64'(sa) * 64'(sb);
                unit_calc = sp;
            end
            FUNCT_MULTU: unit_calc = {32'd0, a} * {32'd0, b};
            FUNCT_DIV: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                unit_calc = {sr, sq};
            end
            FUNCT_DIVU: if (b != 0) unit_calc = {a % b, a / b};
            default: unit_calc = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    logic [5:0]  m_prev_funct;
    logic [31:0] m_prev_op1;
    logic [31:0] m_prev_op2;
    int          m_run;
    int          m_run_now;
    int          m_lat;

    always_comb begin
        m_run_now = 0;
        if (md_funct != FUNCT_NOP)
            m_run_now = (md_funct == m_prev_funct && md_op1 == m_prev_op1 &&
                         md_op2 == m_prev_op2) ? m_run + 1 : 1;
        m_lat = is_mult(md_funct) ? c_mult_lat :
                is_div(md_funct)  ? c_div_lat  : 1000;
        md_result = (m_run_now >= m_lat) ? unit_calc(md_funct, md_op1, md_op2)
                                         : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_prev_funct <= FUNCT_NOP;
            m_prev_op1   <= 32'd0;
            m_prev_op2   <= 32'd0;
            m_run        <= 0;
        end else begin
            m_prev_funct <= md_funct;
            m_prev_op1   <= md_op1;
            m_prev_op2   <= md_op2;
            m_run        <= m_run_now;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply/divide, keep it resident in EX while stalled,
    // optionally hold stall_all for 'hold' DONE cycles, then retire it.
    task automatic run_md(input string tag, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int hold);
        int n_stall;
        bit done_seen;
        n_stall   = 0;
        done_seen = 1'b0;
        req_valid = 1'b1;
        req_funct = f;
        req_op1   = a;
        req_op2   = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_req) begin
                n_stall++;
                if (busy) begin
                    check({tag, "_md_ops"}, {md_op1, md_op2}, {a, b});
                    check({tag, "_md_funct"}, 64'(md_funct), 64'(f));
                end
            end else begin
                done_seen = 1'b1;
                break;
            end
            next_cycle();
        end
        check({tag, "_finished"}, 64'(done_seen), 64'd1);
        check({tag, "_stall_cycles"}, 64'(n_stall), 64'(exp_stall));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_done_busy"}, 64'(busy), 64'd1);
        check({tag, "_done_funct"}, 64'(md_funct), 64'(FUNCT_NOP));
        stall_all = (hold > 0);
        for (int k = 1; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_busy"}, 64'(busy), 64'd1);
            check({tag, "_hold_stall"}, 64'(stall_req), 64'd0);
            check({tag, "_hold_funct"}, 64'(md_funct), 64'(FUNCT_NOP));
        end
        stall_all = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_stall"}, 64'(stall_req), 64'd0);
        check({tag, "_after_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_after_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic mt_write(input logic [5:0] f, input logic [31:0] d);
        req_valid = 1'b1;
        req_funct = f;
        req_op1   = d;
        req_op2   = 32'd0;
        @(negedge clk);
        check("mt_no_stall", 64'(stall_req), 64'd0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("mt_not_busy", 64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_funct = FUNCT_NOP;
        req_op1   = 32'd0;
        req_op2   = 32'd0;
        flush     = 1'b0;
        stall_all = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_funct", 64'(md_funct), 64'(FUNCT_NOP));
        check("rst_ops", {md_op1, md_op2}, 64'd0);
        #2 rst = 1'b1;
        next_cycle();

        // Signed multiply: -3 * 5 = -15.
        run_md("mult", FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, 2,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        next_cycle();

        // Signed divide: 7 / -2 = -3 rem 1.
        run_md("div", FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, 41,
               32'h0000_0001, 32'hFFFF_FFFD, 0);
        next_cycle();

        mt_write(FUNCT_MTHI, 32'h11);
        check("mthi_hi", 64'(hi), 64'h11);
        mt_write(FUNCT_MTLO, 32'h22);
        check("mtlo_lo", 64'(lo), 64'h22);
        check("mtlo_hi_kept", 64'(hi), 64'h11);

        // Divide by zero: no launch, no stall.
        next_cycle();
        req_valid = 1'b1;
        req_funct = FUNCT_DIVU;
        req_op1   = 32'd9;
        req_op2   = 32'd0;
        @(negedge clk);
        check("div0_stall", 64'(stall_req), 64'd0);
        check("div0_busy", 64'(busy), 64'd0);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        check("div0_busy_after", 64'(busy), 64'd0);
        check("div0_hilo", {hi, lo}, {32'h11, 32'h22});

        // Flush in IDLE blocks both acceptance and moves.
        next_cycle();
        req_valid = 1'b1;
        req_funct = FUNCT_MULT;
        req_op1   = 32'd3;
        req_op2   = 32'd3;
        flush     = 1'b1;
        @(negedge clk);
        check("idle_flush_stall", 64'(stall_req), 64'd0);
        next_cycle();
        req_funct = FUNCT_MTHI;
        req_op1   = 32'h5555;
        @(negedge clk);
        check("idle_flush_busy", 64'(busy), 64'd0);
        next_cycle();
        req_valid = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        check("idle_flush_hilo", {hi, lo}, {32'h11, 32'h22});

        // Divide flushed when the counter reads 20 (21st WAIT cycle).
        next_cycle();
        req_valid = 1'b1;
        req_funct = FUNCT_DIV;
        req_op1   = 32'd100;
        req_op2   = 32'd7;
        repeat (21) next_cycle();
        @(negedge clk);
        check("flush_pre_busy", 64'(busy), 64'd1);
        check("flush_pre_stall", 64'(stall_req), 64'd1);
        flush = 1'b1;
        next_cycle();
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_funct", 64'(md_funct), 64'(FUNCT_NOP));
        check("flush_stall", 64'(stall_req), 64'd0);
        check("flush_hilo", {hi, lo}, {32'h11, 32'h22});
        next_cycle();
        mt_write(FUNCT_MTLO, 32'hABCD);
        check("flush_mtlo", {hi, lo}, {32'h11, 32'hABCD});

        // Unsigned multiply held in DONE by stall_all for 3 cycles.
        next_cycle();
        run_md("multu", FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2, 2,
               32'h0000_0001, 32'hFFFF_FFFE, 3);

        // Asynchronous reset in the middle of a divide.
        next_cycle();
        req_valid = 1'b1;
        req_funct = FUNCT_DIV;
        req_op1   = 32'd50;
        req_op2   = 32'd3;
        repeat (10) next_cycle();
        @(negedge clk);
        check("arst_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_stall", 64'(stall_req), 64'd0);
        check("arst_funct", 64'(md_funct), 64'(FUNCT_NOP));
        req_valid = 1'b0;
        next_cycle();
        #2 rst = 1'b1;
        @(negedge clk);
        check("arst_release_busy", 64'(busy), 64'd0);
        check("arst_release_hilo", {hi, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multdiv_ctrl
`default_nettype wire

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing controller for the EX-stage multiply/divide unit. Owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, latches the operands, and holds them stable into the unit for the unit's fixed latency. Stalls the pipeline meanwhile.
- Captures the 64-bit result and commits it to HI/LO. Aborts cleanly on exception flush.

Parameters:
- MULT_LAT, 1: cycles the unit needs with stable operands before a multiply result is valid.
- DIV_LAT, 40: same, for divide.
- CNT_W, 6: counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  EX holds a valid instruction
- req_funct  in  FUNCT_BUS  function code of the EX instruction
- req_op1  in  32  rs value
- req_op2  in  32  rt value
- flush  in  1  exception/eret flush of EX
- stall_all  in  1  global stall from other stages
- stall_req  out  1  request pipeline stall
- md_funct  out  FUNCT_BUS  function code driven to the unit
- md_op1  out  32  operand driven to the unit
- md_op2  out  32  operand driven to the unit
- md_result  in  64  unit result, {hi, lo}
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE, hi=0, lo=0, counter=0, latched operands=0, md_funct=0 (NOP), busy=0.
- Deassertion of reset is synchronised externally.
- States: IDLE, WAIT, DONE.
- IDLE:
  - req_valid & !flush & MULT/MULTU/DIV/DIVU with nonzero divisor (or any multiply): latch funct/op1/op2, load counter with the matching LAT, go to WAIT.
  - stall_req asserts combinationally in this same cycle.
- MTHI/MTLO in IDLE (req_valid & !flush & !stall_all): write hi/lo = req_op1 at the clock edge. No stall, no state change.
- DIV/DIVU with op2 == 0: no launch, no stall, hi/lo unchanged (defined here as our behaviour).
- WAIT:
  - md_funct/md_op1/md_op2 = latched values (registered, stable from the cycle after accept).
  - Counter decrements each cycle.
  - When counter == 1: hi <= md_result[63:32], lo <= md_result[31:0], go to DONE.
  - stall_req = 1 throughout.
  - stall_all does not pause the count.
- Latency: accept in cycle T, hi/lo visible in T+LAT+1. Total stall = LAT+1 cycles (MULT_LAT=1 gives 2).
- DONE:
  - stall_req = 0 and md_funct = NOP; no new accept.
  - If stall_all = 0, return to IDLE next cycle; the instruction leaves EX at this edge.
  - If stall_all = 1, remain in DONE. This prevents re-issuing the same still-resident instruction.
- flush in WAIT or DONE: next state IDLE, hi/lo unchanged, md_funct = NOP next cycle. flush beats a same-cycle capture.
- flush in IDLE blocks acceptance and MTHI/MTLO writes.
- busy = (state != IDLE).
- Operands are forwarded raw. Sign handling stays inside the unit.

Decomposition:
- Shared package/header: the FUNCT_* codes (existing funct header), state encodings, and default latency constants MD_MULT_LAT/MD_DIV_LAT.
- One natural sub-module: hilo_reg, the HI/LO storage with two write ports (capture, mthi/mtlo) and asynchronous active-low reset.
- The FSM and counter stay in multdiv_ctrl.

Test Plan:
- MULT, op1=0xFFFFFFFD, op2=5, bench unit model LAT=1 → stall_req high for 2 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, state IDLE.
- DIV, op1=7, op2=0xFFFFFFFE, LAT=40 → stall_req high for exactly 41 cycles, md_op stable throughout, then lo=0xFFFFFFFD, hi=0x00000001.
- DIVU with op2=0, previous hi=0x11, lo=0x22 → no stall cycle, busy stays 0, hi/lo unchanged.
- DIV accepted, flush asserted at counter==20 → next cycle IDLE, md_funct=NOP, hi/lo unchanged, stall_req=0. A following MTLO 0xABCD writes lo=0xABCD.
- MULTU 0xFFFFFFFF×2 with stall_all high from the DONE cycle for 3 cycles → hi=0x1, lo=0xFFFFFFFE written once; no second WAIT entry; IDLE after stall_all drops.
- rst pulled low mid-DIV (asynchronous, between edges) → outputs immediately hi=lo=0, busy=0, stall_req=0, md_funct=NOP.
